// File: rtl/reorder_buffer_if.sv
// Issue, writeback, commit, lookup and flush signals of the reorder buffer.
// The master side is the core pipeline. The slave side is the buffer.
interface reorder_buffer_if #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int NUM_CDB = 2
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                      alloc_valid;
    logic [REG_W-1:0]          alloc_dest;
    logic                      alloc_ready;
    logic [TAG_W-1:0]          alloc_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      commit_valid;
    logic                      commit_ready;
    logic [TAG_W-1:0]          commit_tag;
    logic [REG_W-1:0]          commit_dest;
    logic [DATA_W-1:0]         commit_data;
    logic [TAG_W-1:0]          rd_tag;
    logic                      rd_ready;
    logic [DATA_W-1:0]         rd_data;
    logic                      flush;
    logic [TAG_W:0]            count;

    modport master (
        output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data,
               commit_ready, rd_tag, flush,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag,
               commit_dest, commit_data, rd_ready, rd_data, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data,
               commit_ready, rd_tag, flush,
        output alloc_ready, alloc_tag, commit_valid, commit_tag,
               commit_dest, commit_data, rd_ready, rd_data, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer. Entries are allocated in order and completed out of order
// by the CDB ports. They retire in order through a valid/ready commit port.
module reorder_buffer #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    reorder_buffer_if.slave   rob
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             done_q, done_d;
    logic [DEPTH-1:0][REG_W-1:0]  dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]             head_q, head_d;
    logic [TAG_W-1:0]             tail_q, tail_d;
    logic [TAG_W:0]               count_q, count_d;

    logic             alloc_fire;
    logic             commit_fire;
    logic             head_ready;
    logic [TAG_W-1:0] wb_tag;

    assign head_ready  = valid_q[head_q] && done_q[head_q];
    assign alloc_fire  = rob.alloc_valid && (count_q != FULL_CNT);
    assign commit_fire = head_ready && rob.commit_ready;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dest_d  = dest_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wb_tag  = '0;

        // Eligibility is judged on the registered state, so for two ports that hit
        // the same tag the ascending loop leaves the higher port's data.
        for (int unsigned i = 0; i < NUM_CDB; i++) begin
            wb_tag = rob.cdb_tag[i*TAG_W +: TAG_W];
            if (rob.cdb_valid[i] && valid_q[wb_tag] && !done_q[wb_tag]) begin
                done_d[wb_tag] = 1'b1;
                data_d[wb_tag] = rob.cdb_data[i*DATA_W +: DATA_W];
            end
        end

        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + TAG_W'(1);
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            dest_d[tail_q]  = rob.alloc_dest;
            data_d[tail_q]  = '0;
            tail_d          = tail_q + TAG_W'(1);
        end

        if (alloc_fire && !commit_fire) begin
            count_d = count_q + (TAG_W+1)'(1);
        end else if (!alloc_fire && commit_fire) begin
            count_d = count_q - (TAG_W+1)'(1);
        end

        if (rob.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            dest_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rob.alloc_ready  = (count_q != FULL_CNT);
    assign rob.alloc_tag    = tail_q;
    assign rob.count        = count_q;
    assign rob.commit_valid = head_ready;
    assign rob.commit_tag   = head_ready ? head_q : '0;
    assign rob.commit_dest  = head_ready ? dest_q[head_q] : '0;
    assign rob.commit_data  = head_ready ? data_q[head_q] : '0;
    assign rob.rd_ready     = valid_q[rob.rd_tag] && done_q[rob.rd_tag];
    assign rob.rd_data      = rob.rd_ready ? data_q[rob.rd_tag] : '0;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer. A program-order queue model is checked against the DUT
// every cycle, alongside directed scenarios and a randomized run.
module tb_reorder_buffer;
    localparam int DEPTH   = 8;
    localparam int DATA_W  = 16;
    localparam int REG_W   = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = $clog2(DEPTH);

    logic clk1;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_CDB(NUM_CDB)) ifc ();

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .NUM_CDB(NUM_CDB)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rob   (ifc.slave)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Model: live instructions in program order, oldest first
    typedef struct {
        int unsigned       tag;
        logic [REG_W-1:0]  dest;
        bit                done;
        logic [DATA_W-1:0] data;
    } ent_t;
    ent_t        q[$];
    int unsigned m_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int find(input int unsigned t);
        foreach (q[k]) if (q[k].tag == t) return k;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail = 0;
    endtask

    task automatic model_update();
        bit          pre_done[DEPTH];
        bit          do_commit;
        bit          do_alloc;
        int          k;
        int unsigned t;
        ent_t        e;
        if (!rst_n) return;
        if (ifc.flush) begin
            model_reset();
            return;
        end
        do_commit = (q.size() > 0) && q[0].done && ifc.commit_ready;
        do_alloc  = ifc.alloc_valid && (q.size() < DEPTH);
        foreach (q[j]) pre_done[j] = q[j].done;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (ifc.cdb_valid[i]) begin
                t = ifc.cdb_tag[i*TAG_W +: TAG_W];
                k = find(t);
                if (k >= 0 && !pre_done[k]) begin
                    q[k].done = 1'b1;
                    q[k].data = ifc.cdb_data[i*DATA_W +: DATA_W];
                end
            end
        end
        if (do_commit) void'(q.pop_front());
        if (do_alloc) begin
            e.tag  = m_tail;
            e.dest = ifc.alloc_dest;
            e.done = 1'b0;
            e.data = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        model_update();
        #1;
    endtask

    task automatic set_cdb(input int p, input bit v, input int unsigned tag, input int unsigned data);
        ifc.cdb_valid[p]                 = v;
        ifc.cdb_tag[p*TAG_W +: TAG_W]    = TAG_W'(tag);
        ifc.cdb_data[p*DATA_W +: DATA_W] = DATA_W'(data);
    endtask

    // Every-cycle comparison against the model
    int          c_k;
    bit          c_cv;
    always @(negedge clk1) begin
        if (chk_en) begin
            c_cv = (q.size() > 0) && q[0].done;
            check("alloc_ready", ifc.alloc_ready, (q.size() < DEPTH) ? 1 : 0);
            check("alloc_tag", ifc.alloc_tag, m_tail);
            check("count", ifc.count, q.size());
            check("commit_valid", ifc.commit_valid, c_cv);
            check("commit_tag", ifc.commit_tag, c_cv ? q[0].tag : 0);
            check("commit_dest", ifc.commit_dest, c_cv ? 32'(q[0].dest) : 0);
            check("commit_data", ifc.commit_data, c_cv ? 32'(q[0].data) : 0);
            c_k = find(ifc.rd_tag);
            check("rd_ready", ifc.rd_ready, (c_k >= 0 && q[c_k].done) ? 1 : 0);
            check("rd_data", ifc.rd_data, (c_k >= 0 && q[c_k].done) ? 32'(q[c_k].data) : 0);
        end
    end

    initial begin
        ifc.alloc_valid  = 0;
        ifc.alloc_dest   = '0;
        ifc.cdb_valid    = '0;
        ifc.cdb_tag      = '0;
        ifc.cdb_data     = '0;
        ifc.commit_ready = 0;
        ifc.rd_tag       = '0;
        ifc.flush        = 0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_en = 1;
        @(posedge clk1);
        @(posedge clk1);
        #1 rst_n = 1'b1;

        check("rst_count", ifc.count, 0);
        check("rst_alloc_ready", ifc.alloc_ready, 1);
        check("rst_alloc_tag", ifc.alloc_tag, 0);
        check("rst_commit_valid", ifc.commit_valid, 0);
        check("rst_rd_data", ifc.rd_data, 0);

        // Fill all entries back to back
        ifc.alloc_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_tag", ifc.alloc_tag, i);
            ifc.alloc_dest = REG_W'(i);
            tick();
        end
        check("full_count", ifc.count, 8);
        check("full_alloc_ready", ifc.alloc_ready, 0);
        check("model_full_size", q.size(), 8);
        tick();
        check("full_ignore_count", ifc.count, 8);
        check("full_ignore_tag", ifc.alloc_tag, 0);
        ifc.alloc_valid = 0;

        // Full with commit and allocate in the same cycle
        set_cdb(0, 1, 0, 16'h0A0A);
        tick();
        set_cdb(0, 0, 0, 0);
        check("full_head_cv", ifc.commit_valid, 1);
        check("full_head_data", ifc.commit_data, 16'h0A0A);
        ifc.commit_ready = 1;
        ifc.alloc_valid  = 1;
        tick();
        ifc.commit_ready = 0;
        check("fc_count", ifc.count, 7);
        check("fc_tag", ifc.alloc_tag, 0);
        check("fc_ready", ifc.alloc_ready, 1);
        tick();
        ifc.alloc_valid = 0;
        check("fc_next_count", ifc.count, 8);
        check("fc_next_tag", ifc.alloc_tag, 1);

        // Flush with 5 entries, 2 done, plus simultaneous allocate and CDB write
        ifc.flush = 1;
        tick();
        ifc.flush = 0;
        ifc.alloc_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        ifc.alloc_valid = 0;
        set_cdb(0, 1, 1, 16'h0101);
        set_cdb(1, 1, 3, 16'h0303);
        tick();
        check("pre_flush_count", ifc.count, 5);
        ifc.flush       = 1;
        ifc.alloc_valid = 1;
        set_cdb(0, 1, 2, 16'h0202);
        set_cdb(1, 0, 0, 0);
        tick();
        ifc.flush       = 0;
        ifc.alloc_valid = 0;
        set_cdb(0, 0, 0, 0);
        check("flush_count", ifc.count, 0);
        check("flush_tail", ifc.alloc_tag, 0);
        check("flush_cv", ifc.commit_valid, 0);
        check("model_flush_size", q.size(), 0);
        for (int t = 0; t < DEPTH; t++) begin
            ifc.rd_tag = TAG_W'(t);
            #1 check("flush_rd_ready", ifc.rd_ready, 0);
        end
        ifc.rd_tag = '0;

        // Out-of-order completion, in-order retire
        ifc.alloc_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ifc.alloc_dest = REG_W'(5 + i);
            tick();
        end
        ifc.alloc_valid = 0;
        set_cdb(1, 1, 2, 16'h0022);
        tick();
        set_cdb(1, 0, 0, 0);
        check("ooo_wait_cv", ifc.commit_valid, 0);
        set_cdb(0, 1, 0, 16'h00AA);
        ifc.commit_ready = 1;
        tick();
        set_cdb(0, 0, 0, 0);
        check("ooo_c0_valid", ifc.commit_valid, 1);
        check("ooo_c0_tag", ifc.commit_tag, 0);
        check("ooo_c0_dest", ifc.commit_dest, 5);
        check("ooo_c0_data", ifc.commit_data, 16'h00AA);
        tick();
        check("ooo_block_cv", ifc.commit_valid, 0);
        tick();
        check("ooo_block_cv2", ifc.commit_valid, 0);
        check("ooo_block_count", ifc.count, 2);
        set_cdb(0, 1, 1, 16'h0011);
        tick();
        set_cdb(0, 0, 0, 0);
        check("ooo_c1_tag", ifc.commit_tag, 1);
        check("ooo_c1_data", ifc.commit_data, 16'h0011);
        tick();
        check("ooo_c2_valid", ifc.commit_valid, 1);
        check("ooo_c2_tag", ifc.commit_tag, 2);
        check("ooo_c2_data", ifc.commit_data, 16'h0022);
        tick();
        ifc.commit_ready = 0;
        check("ooo_empty", ifc.count, 0);

        // Dual CDB writebacks in one cycle
        ifc.flush = 1;
        tick();
        ifc.flush = 0;
        ifc.alloc_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        ifc.alloc_valid = 0;
        set_cdb(0, 1, 1, 16'h1111);
        set_cdb(1, 1, 1, 16'h2222);
        tick();
        ifc.rd_tag = 1;
        #1 check("dual_same_data", ifc.rd_data, 16'h2222);
        set_cdb(0, 1, 3, 16'h3333);
        set_cdb(1, 1, 4, 16'h4444);
        tick();
        set_cdb(0, 0, 0, 0);
        set_cdb(1, 0, 0, 0);
        ifc.rd_tag = 3;
        #1 check("dual_diff_3", ifc.rd_data, 16'h3333);
        ifc.rd_tag = 4;
        #1 check("dual_diff_4", ifc.rd_data, 16'h4444);
        check("dual_rd_ready", ifc.rd_ready, 1);
        ifc.flush = 1;
        tick();
        ifc.flush = 0;

        // Randomized traffic with rare flushes and one mid-run asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            ifc.alloc_valid  = ($urandom_range(0, 3) != 0);
            ifc.alloc_dest   = REG_W'($urandom);
            ifc.commit_ready = ($urandom_range(0, 2) != 0);
            for (int p = 0; p < NUM_CDB; p++)
                set_cdb(p, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom);
            ifc.rd_tag = TAG_W'($urandom);
            ifc.flush  = ($urandom_range(0, 99) == 0);
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check("async_rst_count", ifc.count, 0);
                check("async_rst_cv", ifc.commit_valid, 0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
